// File: rtl/word_width_seq_ctrl.sv
// Top-level sequencer for the word-width datapath: per block, runs LOAD then WRITE.
// Upward ap_ctrl_chain handshake; ap_ctrl_hs handshake to each pipeline.
module word_width_seq_ctrl #(
  parameter int unsigned CNT_W = 16,
  parameter int unsigned CYC_W = 32
) (
  input  logic             ap_clk,
  input  logic             ap_rst_n,
  input  logic             ap_start,
  output logic             ap_ready,
  output logic             ap_done,
  output logic             ap_idle,
  input  logic             ap_continue,
  input  logic [CNT_W-1:0] num_blocks,
  output logic             load_start,
  input  logic             load_ready,
  input  logic             load_done,
  output logic             write_start,
  input  logic             write_ready,
  input  logic             write_done,
  output logic [CNT_W-1:0] blk_idx,
  output logic [CYC_W-1:0] cyc_count
);

  typedef enum logic [1:0] {StIdle, StLoad, StWrite, StDone} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] nblk_q, nblk_d;
  logic [CNT_W-1:0] blk_q, blk_d;
  logic [CYC_W-1:0] cyc_q, cyc_d;
  // Set once the active pipeline has accepted its start; cleared on every state change.
  logic             acc_q, acc_d;

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q <= StIdle;
      nblk_q  <= '0;
      blk_q   <= '0;
      cyc_q   <= '0;
      acc_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      nblk_q  <= nblk_d;
      blk_q   <= blk_d;
      cyc_q   <= cyc_d;
      acc_q   <= acc_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    nblk_d      = nblk_q;
    blk_d       = blk_q;
    cyc_d       = cyc_q;
    acc_d       = acc_q;
    ap_idle     = (state_q == StIdle);
    ap_ready    = (state_q == StIdle) && ap_start;
    ap_done     = (state_q == StDone);
    load_start  = (state_q == StLoad) && !acc_q;
    write_start = (state_q == StWrite) && !acc_q;

    if ((state_q == StLoad || state_q == StWrite) && cyc_q != '1) begin
      cyc_d = cyc_q + CYC_W'(1);
    end

    unique case (state_q)
      StIdle: begin
        if (ap_start) begin
          nblk_d  = num_blocks;
          blk_d   = '0;
          cyc_d   = '0;
          acc_d   = 1'b0;
          state_d = (num_blocks != '0) ? StLoad : StDone;
        end
      end
      StLoad: begin
        if (load_start && load_ready) acc_d = 1'b1;
        if (load_done) begin
          acc_d   = 1'b0;
          state_d = StWrite;
        end
      end
      StWrite: begin
        if (write_start && write_ready) acc_d = 1'b1;
        if (write_done) begin
          acc_d = 1'b0;
          if (blk_q == nblk_q - CNT_W'(1)) begin
            state_d = StDone;
          end else begin
            blk_d   = blk_q + CNT_W'(1);
            state_d = StLoad;
          end
        end
      end
      StDone: begin
        if (ap_continue) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign blk_idx   = blk_q;
  assign cyc_count = cyc_q;

endmodule

// File: tb/tb_word_width_seq_ctrl.sv
// Scoreboard bench: randomized invocations with stub pipelines; expected events come from
// a block-level timing model (phase durations summed, saturated).
module tb_word_width_seq_ctrl;
  localparam int CNT_W   = 4;
  localparam int CYC_W   = 10;
  localparam int CYC_MAX = (1 << CYC_W) - 1;

  logic ap_clk = 1'b0;
  logic ap_rst_n = 1'b1;
  logic ap_start = 1'b0;
  logic ap_continue = 1'b0;
  logic [CNT_W-1:0] num_blocks = '0;
  logic ap_ready, ap_done, ap_idle, load_start, write_start;
  logic load_ready, load_done, write_ready, write_done;
  logic [CNT_W-1:0] blk_idx;
  logic [CYC_W-1:0] cyc_count;

  always #5 ap_clk = ~ap_clk;

  word_width_seq_ctrl #(.CNT_W(CNT_W), .CYC_W(CYC_W)) dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .ap_start(ap_start), .ap_ready(ap_ready),
    .ap_done(ap_done), .ap_idle(ap_idle), .ap_continue(ap_continue),
    .num_blocks(num_blocks), .load_start(load_start), .load_ready(load_ready),
    .load_done(load_done), .write_start(write_start), .write_ready(write_ready),
    .write_done(write_done), .blk_idx(blk_idx), .cyc_count(cyc_count)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  typedef struct {int kind; int idx; int cyc;} ev_t;   // kind: 0 load, 1 write, 2 done
  typedef struct {int r; int d;} dly_t;                // ready offset, done after ready
  ev_t  exp_q[$];
  dly_t dly_q[$];
  int   last_idx, total_cyc, budget;

  function automatic int sat(input int x);
    return (x > CYC_MAX) ? CYC_MAX : x;
  endfunction

  // Pipeline stubs: index 0 = LOAD, 1 = WRITE; each start acceptance pops the next delay pair.
  logic rdy[2];
  logic dn[2];
  int   busy[2], cnt[2];
  dly_t cur[2];
  assign load_ready  = rdy[0];
  assign load_done   = dn[0];
  assign write_ready = rdy[1];
  assign write_done  = dn[1];

  initial begin
    logic st[2];
    for (int i = 0; i < 2; i++) begin
      rdy[i] = 1'b0; dn[i] = 1'b0; busy[i] = 0; cnt[i] = 0;
    end
    forever begin
      @(negedge ap_clk);
      st[0] = load_start;
      st[1] = write_start;
      for (int i = 0; i < 2; i++) begin
        rdy[i] = 1'b0;
        dn[i]  = 1'b0;
        if (!ap_rst_n) begin
          busy[i] = 0;
        end else begin
          if (busy[i] == 0 && st[i]) begin
            busy[i] = 1;
            cnt[i]  = 0;
            if (dly_q.size() == 0) begin
              chk("stub_unexpected_start", i, -1);
              cur[i] = '{r: 0, d: 0};
            end else begin
              cur[i] = dly_q.pop_front();
            end
          end
          if (busy[i] != 0) begin
            if (cnt[i] >= 1)
              chk(i == 0 ? "load_start_level" : "write_start_level", int'(st[i]),
                  int'(cnt[i] <= cur[i].r));
            if (cnt[i] == cur[i].r) rdy[i] = 1'b1;
            if (cnt[i] == cur[i].r + cur[i].d) begin
              dn[i]   = 1'b1;
              busy[i] = 0;
            end
            cnt[i]++;
          end
        end
      end
    end
  end

  task automatic see(input int k);
    ev_t e;
    if (exp_q.size() == 0) begin
      chk("unexpected_event", k, -1);
    end else begin
      e = exp_q.pop_front();
      chk("event_kind", k, e.kind);
      chk("event_blk_idx", int'(blk_idx), e.idx);
      chk("event_cyc_count", int'(cyc_count), e.cyc);
    end
  endtask

  // Monitor: every rising start/done is matched against the scoreboard.
  initial begin
    bit pl, pw, pd;
    pl = 1'b0; pw = 1'b0; pd = 1'b0;
    forever begin
      @(negedge ap_clk);
      if (!ap_rst_n) begin
        pl = 1'b0; pw = 1'b0; pd = 1'b0;
      end else begin
        if (load_start && !pl) see(0);
        if (write_start && !pw) see(1);
        if (ap_done && !pd) see(2);
        pl = load_start; pw = write_start; pd = ap_done;
      end
    end
  end

  task automatic do_reset();
    ap_rst_n = 1'b0;
    ap_start = 1'b0;
    ap_continue = 1'b0;
    #1;
    chk("reset_idle", int'(ap_idle), 1);
    chk("reset_ready", int'(ap_ready), 0);
    chk("reset_done", int'(ap_done), 0);
    chk("reset_load_start", int'(load_start), 0);
    chk("reset_write_start", int'(write_start), 0);
    chk("reset_blk_idx", int'(blk_idx), 0);
    chk("reset_cyc_count", int'(cyc_count), 0);
    exp_q.delete();
    dly_q.delete();
    repeat (2) @(negedge ap_clk);
    ap_rst_n = 1'b1;
    #1;
  endtask

  // Model the invocation, then issue the start and consume ap_ready.
  task automatic issue(input int n, input int rlo, input int rhi, input int dlo, input int dhi);
    int   cum;
    dly_t a;
    cum = 0;
    for (int i = 0; i < n; i++) begin
      for (int k = 0; k < 2; k++) begin
        exp_q.push_back('{kind: k, idx: i, cyc: sat(cum)});
        a.r = $urandom_range(rhi, rlo);
        a.d = $urandom_range(dhi, dlo);
        dly_q.push_back(a);
        cum += a.r + a.d + 1;
      end
    end
    last_idx  = (n == 0) ? 0 : n - 1;
    total_cyc = sat(cum);
    budget    = cum + 20;
    exp_q.push_back('{kind: 2, idx: last_idx, cyc: total_cyc});
    @(negedge ap_clk);
    ap_start   = 1'b1;
    num_blocks = CNT_W'(n);
    #1;
    chk("idle_before_start", int'(ap_idle), 1);
    chk("ready_on_start", int'(ap_ready), 1);
    @(negedge ap_clk);
    ap_start = 1'b0;
    #1;
    if (n == 0) chk("zero_blocks_done_next_cycle", int'(ap_done), 1);
  endtask

  task automatic finish_inv(input int cw);
    int c;
    c = 0;
    while (!ap_done && c < budget) begin
      @(negedge ap_clk);
      #1;
      c++;
    end
    chk("done_within_budget", int'(ap_done), 1);
    if (!ap_done) begin
      do_reset();
      return;
    end
    for (int j = 0; j < cw; j++) begin
      ap_start   = 1'($urandom_range(1, 0));
      num_blocks = CNT_W'($urandom);
      #1;
      chk("done_held", int'(ap_done), 1);
      chk("ready_ignored_in_done", int'(ap_ready), 0);
      @(negedge ap_clk);
      #1;
    end
    ap_start    = 1'b0;
    ap_continue = 1'b1;
    @(negedge ap_clk);
    ap_continue = 1'b0;
    #1;
    chk("idle_after_continue", int'(ap_idle), 1);
    chk("done_released", int'(ap_done), 0);
    chk("blk_idx_held", int'(blk_idx), last_idx);
    chk("cyc_count_held", int'(cyc_count), total_cyc);
  endtask

  initial begin
    bit found;
    #2;
    do_reset();

    issue(3, 2, 2, 0, 0);  finish_inv(0);    // ready+done two cycles after start
    issue(0, 0, 0, 0, 0);  finish_inv(1);    // empty invocation
    issue(2, 1, 2, 1, 2);  finish_inv(5);    // continue held off
    issue(3, 0, 0, 0, 0);  finish_inv(0);    // ready and done together
    issue(2, 4, 4, 1, 3);  finish_inv(2);    // slow ready
    issue(15, 0, 1, 0, 1); finish_inv(1);    // all-ones block count
    issue(8, 40, 60, 40, 60); finish_inv(0); // cycle counter saturates

    for (int t = 0; t < 25; t++) begin
      issue($urandom_range(5, 0), 0, 4, 0, 3);
      finish_inv($urandom_range(5, 0));
    end

    // Reset in the middle of block 1's WRITE phase.
    issue(3, 1, 3, 1, 3);
    found = 1'b0;
    for (int c = 0; c < 200 && !found; c++) begin
      @(negedge ap_clk);
      #1;
      if (blk_idx == CNT_W'(1) && write_start) found = 1'b1;
    end
    chk("reached_mid_write", int'(found), 1);
    do_reset();
    for (int c = 0; c < 4; c++) begin
      @(negedge ap_clk);
      #1;
      chk("no_restart_after_reset", int'(load_start | write_start), 0);
      chk("idle_after_reset", int'(ap_idle), 1);
    end
    issue(2, 0, 3, 0, 3);
    finish_inv(1);

    repeat (3) @(negedge ap_clk);
    chk("scoreboard_drained", exp_q.size(), 0);
    chk("delays_drained", dly_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got 1, expected 0");
    $fatal(1, "timeout");
  end
endmodule
